// File: rtl/spectrum_ram_writer.sv
// Captures one FFT frame and writes bins BIN_LO..BIN_HI (real/imag) into the reference RAM pair.
// Optional macro SPECTRUM_CONJ_EN: store the saturated negated imaginary part (complex conjugate).
module spectrum_ram_writer #(
  parameter int unsigned BIN_LO = 5,
  parameter int unsigned BIN_HI = 2750,
  parameter int unsigned IDX_W  = 13,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  fft_clk,
  input  logic                  sys_rst_n,
  input  logic                  cap_start,
  input  logic [2*DATA_W-1:0]   s_fft_tdata,
  input  logic [IDX_W-1:0]      s_fft_tuser,
  input  logic                  s_fft_tvalid,
  input  logic                  s_fft_tlast,
  output logic                  ram_wr_en,
  output logic [ADDR_W-1:0]     ram_wr_addr,
  output logic [DATA_W-1:0]     ram_wr_real,
  output logic [DATA_W-1:0]     ram_wr_imag,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic                  cap_err,
  output logic [ADDR_W:0]       wr_count
);

  localparam logic [IDX_W-1:0] LoIdx = IDX_W'(BIN_LO);
  localparam logic [IDX_W-1:0] HiIdx = IDX_W'(BIN_HI);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

  state_e              r_state;
  logic                r_start_q;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_real;
  logic [DATA_W-1:0]   r_wr_imag;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W:0]     r_wr_count;

  state_e              w_state_d;
  logic                w_wr_en_d;
  logic [ADDR_W-1:0]   w_wr_addr_d;
  logic [DATA_W-1:0]   w_wr_real_d;
  logic [DATA_W-1:0]   w_wr_imag_d;
  logic                w_busy_d;
  logic                w_done_d;
  logic                w_err_d;
  logic [ADDR_W:0]     w_wr_count_d;

  logic                w_start_edge;
  logic                w_in_win;
  logic                w_process;
  logic [IDX_W-1:0]    w_exp_idx;
  logic [ADDR_W-1:0]   w_beat_addr;
  logic [DATA_W-1:0]   w_real_in;
  logic [DATA_W-1:0]   w_imag_in;
  logic [DATA_W-1:0]   w_imag_wr;

  assign w_start_edge = cap_start & ~r_start_q;
  assign w_in_win     = (s_fft_tuser >= LoIdx) && (s_fft_tuser <= HiIdx);
  assign w_exp_idx    = LoIdx + IDX_W'(r_wr_count);
  assign w_beat_addr  = ADDR_W'(s_fft_tuser - LoIdx);
  assign w_real_in    = s_fft_tdata[DATA_W-1:0];
  assign w_imag_in    = s_fft_tdata[2*DATA_W-1:DATA_W];

`ifdef SPECTRUM_CONJ_EN
  // Most-negative input has no positive twin; clamp to max positive.
  assign w_imag_wr = (w_imag_in == {1'b1, {(DATA_W-1){1'b0}}}) ?
                     {1'b0, {(DATA_W-1){1'b1}}} : ({DATA_W{1'b0}} - w_imag_in);
`else
  assign w_imag_wr = w_imag_in;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_wr_en_d    = 1'b0;
    w_wr_addr_d  = r_wr_addr;
    w_wr_real_d  = r_wr_real;
    w_wr_imag_d  = r_wr_imag;
    w_done_d     = r_done;
    w_err_d      = r_err;
    w_wr_count_d = r_wr_count;
    w_process    = 1'b0;

    unique case (r_state)
      StIdle, StDone: begin
        if (w_start_edge) begin
          w_state_d    = StArm;
          w_done_d     = 1'b0;
          w_err_d      = 1'b0;
          w_wr_count_d = '0;
        end
      end
      StArm: begin
        // Only a frame-start beat arms the capture; that beat is then handled like any other.
        if (s_fft_tvalid && (s_fft_tuser == '0)) begin
          w_state_d = StCapture;
          w_process = 1'b1;
        end
      end
      StCapture: begin
        w_process = s_fft_tvalid;
      end
      default: w_state_d = StIdle;
    endcase

    if (w_process) begin
      if (w_in_win) begin
        if (s_fft_tuser != w_exp_idx) begin
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_wr_en_d    = 1'b1;
          w_wr_addr_d  = w_beat_addr;
          w_wr_real_d  = w_real_in;
          w_wr_imag_d  = w_imag_wr;
          w_wr_count_d = r_wr_count + 1'b1;
          if (s_fft_tuser == HiIdx) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
          end else if (s_fft_tlast) begin
            w_err_d   = 1'b1;
            w_state_d = StIdle;
          end
        end
      end else if (s_fft_tlast) begin
        w_err_d   = 1'b1;
        w_state_d = StIdle;
      end
    end

    w_busy_d = (w_state_d == StArm) || (w_state_d == StCapture);
  end

  always_ff @(posedge fft_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= StIdle;
      r_start_q  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_real  <= '0;
      r_wr_imag  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_d;
      r_start_q  <= cap_start;
      r_wr_en    <= w_wr_en_d;
      r_wr_addr  <= w_wr_addr_d;
      r_wr_real  <= w_wr_real_d;
      r_wr_imag  <= w_wr_imag_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
      r_wr_count <= w_wr_count_d;
    end
  end

  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_real = r_wr_real;
  assign ram_wr_imag = r_wr_imag;
  assign cap_busy    = r_busy;
  assign cap_done    = r_done;
  assign cap_err     = r_err;
  assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_spectrum_ram_writer.sv
// Directed bench for spectrum_ram_writer: expected RAM writes are queued as beats are driven
// and popped as the DUT strobes ram_wr_en.
module tb_spectrum_ram_writer;
  localparam int BIN_LO = 5;
  localparam int BIN_HI = 2750;
  localparam int IDX_W  = 13;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W+2*DATA_W-1:0] wr_t;

  logic                fft_clk = 1'b0;
  logic                sys_rst_n = 1'b1;
  logic                cap_start = 1'b0;
  logic [2*DATA_W-1:0] s_fft_tdata = '0;
  logic [IDX_W-1:0]    s_fft_tuser = '0;
  logic                s_fft_tvalid = 1'b0;
  logic                s_fft_tlast = 1'b0;
  logic                ram_wr_en;
  logic [ADDR_W-1:0]   ram_wr_addr;
  logic [DATA_W-1:0]   ram_wr_real;
  logic [DATA_W-1:0]   ram_wr_imag;
  logic                cap_busy;
  logic                cap_done;
  logic                cap_err;
  logic [ADDR_W:0]     wr_count;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #5 fft_clk = ~fft_clk;

  spectrum_ram_writer #(
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI),
    .IDX_W  (IDX_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .fft_clk      (fft_clk),
    .sys_rst_n    (sys_rst_n),
    .cap_start    (cap_start),
    .s_fft_tdata  (s_fft_tdata),
    .s_fft_tuser  (s_fft_tuser),
    .s_fft_tvalid (s_fft_tvalid),
    .s_fft_tlast  (s_fft_tlast),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_real  (ram_wr_real),
    .ram_wr_imag  (ram_wr_imag),
    .cap_busy     (cap_busy),
    .cap_done     (cap_done),
    .cap_err      (cap_err),
    .wr_count     (wr_count)
  );

  function automatic logic [15:0] exp_imag(input logic [15:0] x);
`ifdef SPECTRUM_CONJ_EN
    if (x == 16'h8000) return 16'h7fff;
    return 16'h0000 - x;
`else
    return x;
`endif
  endfunction

  function automatic logic [31:0] dflt(input int idx);
    logic [15:0] v;
    v = idx[15:0];
    return {v, ~v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    wr_t e;
    if (ram_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL spurious_write observed addr=%0d expected no write", ram_wr_addr);
      end else begin
        e = exp_q.pop_front();
        chk("write", {ram_wr_addr, ram_wr_real, ram_wr_imag}, e);
      end
    end
  endtask

  task automatic push(input int idx, input logic [31:0] data);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(idx - BIN_LO);
    exp_q.push_back({a, data[15:0], exp_imag(data[31:16])});
  endtask

  // Drives one cycle of input, then checks the write produced by the previous cycle.
  task automatic step(input logic v, input int idx, input logic [31:0] data, input logic last);
    @(posedge fft_clk);
    #1;
    s_fft_tvalid = v;
    s_fft_tuser  = idx[IDX_W-1:0];
    s_fft_tdata  = data;
    s_fft_tlast  = last;
    @(negedge fft_clk);
    check_out();
  endtask

  task automatic beat(input int idx, input logic last, input logic expect_wr);
    if (expect_wr) push(idx, dflt(idx));
    step(1'b1, idx, dflt(idx), last);
  endtask

  task automatic pulse_start();
    cap_start = 1'b1;
    step(1'b0, 0, 32'h0, 1'b0);
    cap_start = 1'b0;
    chk("armed_busy", cap_busy, 1);
    chk("armed_done", cap_done, 0);
    chk("armed_err", cap_err, 0);
    chk("armed_count", wr_count, 0);
  endtask

  task automatic frame(input logic cap, input logic gaps);
    for (int i = 0; i < 4096; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0)
          step(1'b0, int'($urandom_range(0, 4095)), $urandom(), 1'b0);
      end
      beat(i, i == 4095, cap && i >= BIN_LO && i <= BIN_HI);
      if (cap && i == BIN_HI) chk("done_early", cap_done, 0);
      if (cap && i == BIN_HI + 1) chk("done_timing", cap_done, 1);
    end
  endtask

  task automatic check_done();
    step(1'b0, 0, 32'h0, 1'b0);
    chk("done", cap_done, 1);
    chk("done_err", cap_err, 0);
    chk("done_count", wr_count, BIN_HI - BIN_LO + 1);
    chk("done_busy", cap_busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] d;
    // Reset state
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_busy", cap_busy, 0);
    chk("rst_done", cap_done, 0);
    chk("rst_err", cap_err, 0);
    chk("rst_count", wr_count, 0);
    repeat (3) @(negedge fft_clk);
    sys_rst_n = 1'b1;

    // Full contiguous frame
    pulse_start();
    frame(1'b1, 1'b0);
    check_done();

    // Arm mid-frame: nothing written until the next frame start
    for (int i = 0; i < 100; i++) beat(i, 1'b0, 1'b0);
    cap_start = 1'b1;
    beat(100, 1'b0, 1'b0);
    cap_start = 1'b0;
    for (int i = 101; i < 4096; i++) beat(i, i == 4095, 1'b0);
    chk("midarm_count", wr_count, 0);
    chk("midarm_busy", cap_busy, 1);
    chk("midarm_done", cap_done, 0);
    frame(1'b1, 1'b0);
    check_done();

    // Gapped stream
    pulse_start();
    frame(1'b1, 1'b1);
    check_done();

    // Short frame: tlast on index 1000
    pulse_start();
    for (int i = 0; i <= 1000; i++) beat(i, i == 1000, i >= BIN_LO);
    repeat (2) step(1'b0, 0, 32'h0, 1'b0);
    chk("short_err", cap_err, 1);
    chk("short_done", cap_done, 0);
    chk("short_busy", cap_busy, 0);
    chk("short_count", wr_count, 996);
    chk("short_queue", exp_q.size(), 0);
    pulse_start();

    // Index jump: 299 then 301
    for (int i = 0; i < 300; i++) beat(i, 1'b0, i >= BIN_LO);
    beat(301, 1'b0, 1'b0);
    step(1'b0, 0, 32'h0, 1'b0);
    chk("jump_err", cap_err, 1);
    chk("jump_count", wr_count, 295);
    chk("jump_busy", cap_busy, 0);
    for (int i = 302; i < 310; i++) beat(i, 1'b0, 1'b0);
    chk("jump_done", cap_done, 0);
    chk("jump_queue", exp_q.size(), 0);

    // Conjugate corner values, then reset mid-capture
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      d = dflt(i);
      if (i == 5) d[31:16] = 16'h8000;
      if (i == 6) d[31:16] = 16'h0003;
      if (i >= BIN_LO) push(i, d);
      step(1'b1, i, d, 1'b0);
    end
    step(1'b0, 0, 32'h0, 1'b0);
    chk("pre_rst_queue", exp_q.size(), 0);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs",
        {ram_wr_en, ram_wr_addr, ram_wr_real, ram_wr_imag, cap_busy, cap_done, cap_err, wr_count},
        0);
    @(negedge fft_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) beat(i, 1'b0, 1'b0);
    chk("post_rst_done", cap_done, 0);
    chk("post_rst_busy", cap_busy, 0);
    chk("post_rst_count", wr_count, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
